// File: rtl/totient_pkg.sv
`default_nettype none
// ============================================================================
// Module      : totient_pkg
// Description : Shared types and segment constants for the totient sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package totient_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int IDX_W = 4;

    // Patterns are {A,B,C,D,E,F,G}, active high.
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage : totient_pkg
`default_nettype wire

// File: rtl/totient_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : totient_seq_ctrl_if
// Description : Control inputs and display outputs of the totient sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface totient_seq_ctrl_if;
    import totient_pkg::*;

    logic             start;
    logic             stop;
    logic             step;
    logic             dir;
    logic             load;
    logic [IDX_W-1:0] load_val;
    logic             blank;
    logic [IDX_W-1:0] idx;
    logic [3:0]       phi;
    logic             A, B, C, D, E, F, G;
    logic             busy;
    logic             wrap;

    modport master (
        output start, stop, step, dir, load, load_val, blank,
        input  idx, phi, A, B, C, D, E, F, G, busy, wrap
    );

    modport slave (
        input  start, stop, step, dir, load, load_val, blank,
        output idx, phi, A, B, C, D, E, F, G, busy, wrap
    );

endinterface : totient_seq_ctrl_if
`default_nettype wire

// File: rtl/totient_seg_rom.sv
`default_nettype none
// ============================================================================
// Module      : totient_seg_rom
// Description : Combinational lookup idx -> phi(idx+1) and its segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module totient_seg_rom
    import totient_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [3:0]       o_phi,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_phi = 4'd1;
        case (i_idx)
            4'd0:    o_phi = 4'd1;
            4'd1:    o_phi = 4'd1;
            4'd2:    o_phi = 4'd2;
            4'd3:    o_phi = 4'd2;
            4'd4:    o_phi = 4'd4;
            4'd5:    o_phi = 4'd2;
            4'd6:    o_phi = 4'd6;
            4'd7:    o_phi = 4'd4;
            4'd8:    o_phi = 4'd6;
            4'd9:    o_phi = 4'd4;
            4'd10:   o_phi = 4'd10;
            4'd11:   o_phi = 4'd4;
            4'd12:   o_phi = 4'd12;
            4'd13:   o_phi = 4'd6;
            4'd14:   o_phi = 4'd8;
            default: o_phi = 4'd8;
        endcase
    end

    always_comb begin
        o_seg = SEG_OFF;
        case (o_phi)
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd4:    o_seg = SEG_4;
            4'd6:    o_seg = SEG_6;
            4'd8:    o_seg = SEG_8;
            4'd10:   o_seg = SEG_A;
            4'd12:   o_seg = SEG_C;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : totient_seg_rom
`default_nettype wire

// File: rtl/totient_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : totient_seq_ctrl
// Description : Run/pause/step sequencer driving the Euler-totient display.
// Revision    : 1.0 - initial release
// ============================================================================
module totient_seq_ctrl
    import totient_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int PS_W     = 8
)(
    input  logic               CLK_LABEL,
    input  logic               R,
    totient_seq_ctrl_if.slave  bus
);

    localparam logic [PS_W-1:0] c_PS_MAX = PS_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [PS_W-1:0]  r_ps;
    logic [PS_W-1:0]  w_ps_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_idx_adv;
    logic             r_wrap;
    logic             w_wrap_next;
    logic             w_adv;
    logic [3:0]       w_phi;
    logic [6:0]       w_seg;

    always_ff @(posedge CLK_LABEL) begin
        if (R) begin
            r_state <= IDLE;
            r_ps    <= '0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ps    <= w_ps_next;
            r_idx   <= w_idx_next;
            r_wrap  <= w_wrap_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ps_next    = r_ps;
        w_idx_next   = r_idx;
        w_wrap_next  = 1'b0;
        w_adv        = 1'b0;
        w_idx_adv    = bus.dir ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));

        // stop dominates start in every state, so IDLE with both goes to PAUSE
        case (r_state)
            IDLE: begin
                if (bus.stop)       w_next_state = PAUSE;
                else if (bus.start) w_next_state = RUN;
            end
            RUN: begin
                if (bus.stop)       w_next_state = PAUSE;
            end
            PAUSE: begin
                if (!bus.stop && bus.start) w_next_state = RUN;
            end
            default: w_next_state = IDLE;
        endcase

        if (r_state == RUN) begin
            if (r_ps == c_PS_MAX) begin
                w_adv     = 1'b1;
                w_ps_next = '0;
            end else begin
                w_ps_next = r_ps + PS_W'(1);
            end
        end else begin
            w_adv = bus.step;
        end

        if ((r_state != RUN) && (w_next_state == RUN)) w_ps_next = '0;

        if (bus.load) begin
            w_idx_next = bus.load_val;
            w_ps_next  = '0;
        end else if (w_adv) begin
            w_idx_next  = w_idx_adv;
            w_wrap_next = bus.dir ? (r_idx == '0) : (r_idx == '1);
        end
    end

    totient_seg_rom u_rom (
        .i_idx (r_idx),
        .o_phi (w_phi),
        .o_seg (w_seg)
    );

    assign bus.idx  = r_idx;
    assign bus.phi  = w_phi;
    assign bus.busy = (r_state == RUN);
    assign bus.wrap = r_wrap;
    assign {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = bus.blank ? SEG_OFF : w_seg;

endmodule : totient_seq_ctrl
`default_nettype wire

// File: tb/tb_totient_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_totient_seq_ctrl
// Description : Directed self-checking bench for the totient sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_totient_seq_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    totient_seq_ctrl_if bus ();

    totient_seq_ctrl #(
        .TICK_DIV (4),
        .PS_W     (8)
    ) dut (
        .CLK_LABEL (clk),
        .R         (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {idx[4], phi[4], seg{A..G}[7], busy, wrap}
    logic [16:0] w_obs;
    assign w_obs = {bus.idx, bus.phi, bus.A, bus.B, bus.C, bus.D, bus.E,
                    bus.F, bus.G, bus.busy, bus.wrap};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if (w_obs !== {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state obs=%h expected=%h", w_obs, {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (w_obs !== {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL idle_hold cyc=%0d obs=%h expected=%h", i, w_obs, {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_run_rate();
        bus.dir   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec++;
        if ({bus.idx, bus.busy} !== {4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL run_e0 idx=%0d busy=%b expected idx=0 busy=1", bus.idx, bus.busy);
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) begin
                n_vec++;
                if (bus.idx !== 4'd0) begin
                    n_err++;
                    $display("FAIL run_e3 idx=%0d expected=0", bus.idx);
                end
            end
            if (k == 4) begin
                n_vec++;
                if ({bus.idx, bus.phi, bus.busy} !== {4'd1, 4'd1, 1'b1}) begin
                    n_err++;
                    $display("FAIL run_e4 idx=%0d phi=%0d busy=%b expected 1/1/1", bus.idx, bus.phi, bus.busy);
                end
            end
            if (k == 8) begin
                n_vec++;
                if ({bus.idx, bus.phi, bus.busy} !== {4'd2, 4'd2, 1'b1}) begin
                    n_err++;
                    $display("FAIL run_e8 idx=%0d phi=%0d busy=%b expected 2/2/1", bus.idx, bus.phi, bus.busy);
                end
            end
            if (k == 12) begin
                n_vec++;
                if ({bus.idx, bus.phi, bus.busy} !== {4'd3, 4'd2, 1'b1}) begin
                    n_err++;
                    $display("FAIL run_e12 idx=%0d phi=%0d busy=%b expected 3/2/1", bus.idx, bus.phi, bus.busy);
                end
            end
        end
    endtask

    task automatic test_up_wrap();
        bus.load_val = 4'd14;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        n_vec++;
        if ({bus.idx, bus.wrap} !== {4'd14, 1'b0}) begin
            n_err++;
            $display("FAIL up_load idx=%0d wrap=%b expected 14/0", bus.idx, bus.wrap);
        end
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if ({bus.idx, bus.wrap} !== {4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL up_15 idx=%0d wrap=%b expected 15/0", bus.idx, bus.wrap);
        end
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (w_obs !== {4'd0, 4'd1, 7'b0110000, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL up_wrap obs=%h expected=%h", w_obs, {4'd0, 4'd1, 7'b0110000, 1'b1, 1'b1});
        end
        tick();
        n_vec++;
        if ({bus.idx, bus.wrap} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL up_wrap_clear idx=%0d wrap=%b expected 0/0", bus.idx, bus.wrap);
        end
    endtask

    task automatic test_down_step_wrap();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL pause_busy busy=%b expected=0", bus.busy);
        end
        bus.load_val = 4'd0;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        bus.dir      = 1'b1;
        bus.step     = 1'b1;
        tick();
        bus.step     = 1'b0;
        n_vec++;
        if (w_obs !== {4'd15, 4'd8, 7'b1111111, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL down_wrap obs=%h expected=%h", w_obs, {4'd15, 4'd8, 7'b1111111, 1'b0, 1'b1});
        end
        tick();
        n_vec++;
        if ({bus.idx, bus.wrap} !== {4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL down_wrap_clear idx=%0d wrap=%b expected 15/0", bus.idx, bus.wrap);
        end
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        n_vec++;
        if ({bus.idx, bus.phi, bus.wrap} !== {4'd14, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL down_step2 idx=%0d phi=%0d wrap=%b expected 14/8/0", bus.idx, bus.phi, bus.wrap);
        end
    endtask

    task automatic test_priority_blank();
        bus.load_val = 4'd12;
        bus.load     = 1'b1;
        bus.step     = 1'b1;
        tick();
        bus.load     = 1'b0;
        bus.step     = 1'b0;
        n_vec++;
        if (w_obs !== {4'd12, 4'd12, 7'b1001110, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL load_prio obs=%h expected=%h", w_obs, {4'd12, 4'd12, 7'b1001110, 1'b0, 1'b0});
        end
        bus.blank = 1'b1;
        #1;
        n_vec++;
        if (w_obs !== {4'd12, 4'd12, 7'b0000000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL blank obs=%h expected=%h", w_obs, {4'd12, 4'd12, 7'b0000000, 1'b0, 1'b0});
        end
        bus.blank = 1'b0;
        #1;
        n_vec++;
        if ({bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} !== 7'b1001110) begin
            n_err++;
            $display("FAIL unblank seg=%b expected=1001110", {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G});
        end
    endtask

    task automatic test_reset_mid_run();
        bus.dir      = 1'b0;
        bus.load_val = 4'd15;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if ({bus.idx, bus.busy, bus.wrap} !== {4'd15, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL pre_reset idx=%0d busy=%b wrap=%b expected 15/1/0", bus.idx, bus.busy, bus.wrap);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (w_obs !== {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset obs=%h expected=%h", w_obs, {4'd0, 4'd1, 7'b0110000, 1'b0, 1'b0});
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_vec++;
        if ({bus.idx, bus.busy} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL stop_wins idx=%0d busy=%b expected 0/0", bus.idx, bus.busy);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if ({bus.idx, bus.busy} !== {4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL restart_e3 idx=%0d busy=%b expected 0/1", bus.idx, bus.busy);
        end
        tick();
        n_vec++;
        if ({bus.idx, bus.busy, bus.wrap} !== {4'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL restart_e4 idx=%0d busy=%b wrap=%b expected 1/1/0", bus.idx, bus.busy, bus.wrap);
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.step     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        bus.blank    = 1'b0;

        test_reset();
        test_run_rate();
        test_up_wrap();
        test_down_step_wrap();
        test_priority_blank();
        test_reset_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_totient_seq_ctrl
`default_nettype wire
